fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues reads to a fixed-latency instruction
// RAM, stages each returned word with its address, and handles stall,
// branch redirect and halt.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   run, stall, halt      start from IDLE / hold issue / stop after fetch
//   branch_valid/_target  redirect request and address
//   iram_en, iram_rd_en   RAM enables (asserted only on an issue cycle)
//   iram_addr, iram_rdata RAM address (always pc) and returned data
//   pc                    next fetch address
//   stage_ld              stage-register load strobe (LOAD state)
//   stage_instr/_pc/_valid staged instruction, its address, valid flag
//   busy                  state is ISSUE, WAIT or LOAD
module fetch_sequencer #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter int              RAM_LAT  = 1,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               stall,
    input  logic               halt,
    input  logic               branch_valid,
    input  logic [PC_W-1:0]    branch_target,
    output logic               iram_en,
    output logic               iram_rd_en,
    output logic [PC_W-1:0]    iram_addr,
    input  logic [INSTR_W-1:0] iram_rdata,
    output logic [PC_W-1:0]    pc,
    output logic               stage_ld,
    output logic [INSTR_W-1:0] stage_instr,
    output logic [PC_W-1:0]    stage_pc,
    output logic               stage_valid,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_LOAD,
        S_HALTED
    } state_e;

    // WAIT lasts RAM_LAT-1 cycles; the counter is loaded with RAM_LAT-2
    // and WAIT exits when it reads zero.
    localparam int          WAIT_INIT_I = (RAM_LAT > 1) ? RAM_LAT - 2 : 0;
    localparam logic [1:0]  WAIT_INIT   = WAIT_INIT_I[1:0];
    localparam logic        HAS_WAIT    = (RAM_LAT > 1);

    state_e               state_q;
    logic [PC_W-1:0]      pc_q;
    logic [PC_W-1:0]      issued_q;
    logic [PC_W-1:0]      stage_pc_q;
    logic [INSTR_W-1:0]   stage_instr_q;
    logic                 stage_valid_q;
    logic                 halt_pend_q;
    logic [1:0]           wait_cnt_q;

    logic                 active;
    logic                 do_issue;
    logic                 do_load;
    logic [PC_W-1:0]      pc_inc_d;

    assign active   = (state_q == S_ISSUE) || (state_q == S_WAIT)
                   || (state_q == S_LOAD);
    // Branch and halt take priority over an issue in the same cycle, so
    // the RAM is not enabled for an address that would be thrown away.
    assign do_issue = !reset && (state_q == S_ISSUE) && !branch_valid
                   && !halt && !stall;
    assign do_load  = !reset && (state_q == S_LOAD) && !branch_valid;
    assign pc_inc_d = pc_q + PC_W'(1);

    assign iram_en     = do_issue;
    assign iram_rd_en  = do_issue;
    assign iram_addr   = pc_q;
    assign pc          = pc_q;
    assign stage_ld    = do_load;
    assign stage_instr = stage_instr_q;
    assign stage_pc    = stage_pc_q;
    assign stage_valid = stage_valid_q;
    assign busy        = !reset && active;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            issued_q      <= '0;
            stage_pc_q    <= '0;
            stage_instr_q <= '0;
            stage_valid_q <= 1'b0;
            halt_pend_q   <= 1'b0;
            wait_cnt_q    <= '0;
        end else if (active && branch_valid) begin
            // Redirect cancels the in-flight fetch. A halt requested now
            // or earlier still wins once pc has been redirected.
            pc_q          <= branch_target;
            stage_valid_q <= 1'b0;
            halt_pend_q   <= 1'b0;
            wait_cnt_q    <= '0;
            state_q       <= (halt || halt_pend_q) ? S_HALTED : S_ISSUE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (halt) begin
                        state_q <= S_HALTED;
                    end else if (!stall) begin
                        issued_q   <= pc_q;
                        pc_q       <= pc_inc_d;
                        wait_cnt_q <= WAIT_INIT;
                        state_q    <= HAS_WAIT ? S_WAIT : S_LOAD;
                    end
                end
                S_WAIT: begin
                    if (halt) halt_pend_q <= 1'b1;
                    if (wait_cnt_q == 2'd0) begin
                        state_q <= S_LOAD;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                S_LOAD: begin
                    stage_instr_q <= iram_rdata;
                    stage_pc_q    <= issued_q;
                    stage_valid_q <= 1'b1;
                    halt_pend_q   <= 1'b0;
                    state_q <= (halt || halt_pend_q) ? S_HALTED : S_ISSUE;
                end
                S_HALTED: begin
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: three instances (RAM_LAT 1, 2, 3) with
// RAM models returning addr+16'h0100; loads checked by a scoreboard.
module tb_fetch_sequencer;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
        int          cyc;
    } exp_t;

    logic             clk;
    logic [2:0]       rst;
    logic             run, stall, halt, bv;
    logic [7:0]       bt;
    logic [2:0]       en, rd, ld, sv, busy;
    logic [2:0][7:0]  addr, pc, spc;
    logic [2:0][15:0] sinstr;

    int   cyc;
    int   vecs;
    int   errs;
    exp_t sbq[3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic expect_ld(int d, logic [7:0] a, int c);
        exp_t e;
        e.pc    = a;
        e.instr = {8'h01, a};
        e.cyc   = c;
        sbq[d].push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(int t);
        while (cyc < t) tick();
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [15:0] pipe [g+1];
        logic [15:0] rdata;

        fetch_sequencer #(
            .PC_W(8), .INSTR_W(16), .RAM_LAT(g + 1), .RESET_PC(8'h00)
        ) u_dut (
            .clk(clk),
            .reset(rst[g]),
            .run(run),
            .stall(stall),
            .halt(halt),
            .branch_valid(bv),
            .branch_target(bt),
            .iram_en(en[g]),
            .iram_rd_en(rd[g]),
            .iram_addr(addr[g]),
            .iram_rdata(rdata),
            .pc(pc[g]),
            .stage_ld(ld[g]),
            .stage_instr(sinstr[g]),
            .stage_pc(spc[g]),
            .stage_valid(sv[g]),
            .busy(busy[g])
        );

        always @(posedge clk) begin
            pipe[0] <= (en[g] && rd[g]) ? {8'h01, addr[g]} : 16'hDEAD;
            for (int i = 1; i <= g; i++) pipe[i] <= pipe[i-1];
        end
        assign rdata = pipe[g];

        always @(negedge clk) begin
            exp_t e;
            int   c;
            if (ld[g]) begin
                c = cyc;
                if (sbq[g].size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL dut%0d unexpected stage_ld: addr %0h at cycle %0d, expected none",
                             g, addr[g], c);
                end else begin
                    e = sbq[g].pop_front();
                    @(posedge clk);
                    #1;
                    check($sformatf("dut%0d ld_cycle", g), c, e.cyc);
                    check($sformatf("dut%0d stage_pc", g), spc[g], e.pc);
                    check($sformatf("dut%0d stage_instr", g), sinstr[g], e.instr);
                    check($sformatf("dut%0d stage_valid", g), sv[g], 1);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        vecs  = 0;
        errs  = 0;
        rst   = 3'b111;
        run   = 1'b0;
        stall = 1'b0;
        halt  = 1'b0;
        bv    = 1'b0;
        bt    = 8'h00;

        // reset state of all instances
        repeat (3) tick();
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst%0d pc", g), pc[g], 8'h00);
            check($sformatf("rst%0d busy", g), busy[g], 0);
            check($sformatf("rst%0d iram_en", g), en[g], 0);
            check($sformatf("rst%0d stage_ld", g), ld[g], 0);
            check($sformatf("rst%0d stage_valid", g), sv[g], 0);
            check($sformatf("rst%0d stage_pc", g), spc[g], 8'h00);
            check($sformatf("rst%0d stage_instr", g), sinstr[g], 16'h0);
        end

        // RAM_LAT=1 streaming: loads every 2nd cycle
        tick();
        rst[0] = 1'b0;
        tick();
        run = 1'b1;
        k = cyc;
        expect_ld(0, 8'h00, k + 2);
        expect_ld(0, 8'h01, k + 4);
        expect_ld(0, 8'h02, k + 6);
        go(k + 1);
        run = 1'b0;
        @(negedge clk);
        check("l1 issue en", en[0], 1);
        check("l1 issue addr", addr[0], 8'h00);
        go(k + 2);
        @(negedge clk);
        check("l1 load pc", pc[0], 8'h01);
        check("l1 load en", en[0], 0);
        go(k + 7);
        rst[0] = 1'b1;
        @(negedge clk);
        check("l1 rst en gated", en[0], 0);
        check("l1 rst busy gated", busy[0], 0);
        check("l1 valid held", sv[0], 1);
        go(k + 8);
        @(negedge clk);
        check("l1 rst pc", pc[0], 8'h00);
        check("l1 rst valid", sv[0], 0);

        // RAM_LAT=3: one issue in four cycles
        tick();
        rst[2] = 1'b0;
        tick();
        run = 1'b1;
        k = cyc;
        n = 0;
        expect_ld(2, 8'h00, k + 4);
        expect_ld(2, 8'h01, k + 8);
        for (int i = 1; i <= 8; i++) begin
            go(k + i);
            run = 1'b0;
            @(negedge clk);
            if (en[2]) n++;
            if (i == 2) check("l3 pc after issue", pc[2], 8'h01);
            if (i == 4) check("l3 first ld", ld[2], 1);
            if (i == 5) check("l3 pc before 2nd", pc[2], 8'h01);
            if (i == 5) check("l3 2nd issue en", en[2], 1);
            if (i == 6) check("l3 pc after 2nd", pc[2], 8'h02);
        end
        check("l3 en count", n, 2);
        go(k + 9);
        rst[2] = 1'b1;
        go(k + 10);

        // RAM_LAT=2: stall at pc=5, then halt during WAIT of fetch 7
        tick();
        rst[1] = 1'b0;
        tick();
        run = 1'b1;
        k = cyc;
        for (int i = 0; i < 5; i++) expect_ld(1, 8'(i), k + 3 + 3 * i);
        expect_ld(1, 8'h05, k + 23);
        expect_ld(1, 8'h06, k + 26);
        expect_ld(1, 8'h07, k + 29);
        go(k + 1);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            go(k + 16 + i);
            stall = 1'b1;
            @(negedge clk);
            check($sformatf("stall%0d en", i), en[1], 0);
            check($sformatf("stall%0d pc", i), pc[1], 8'h05);
        end
        go(k + 21);
        stall = 1'b0;
        @(negedge clk);
        check("resume en", en[1], 1);
        check("resume addr", addr[1], 8'h05);
        go(k + 28);
        halt = 1'b1;
        @(negedge clk);
        check("halt wait busy", busy[1], 1);
        go(k + 29);
        halt = 1'b0;
        @(negedge clk);
        check("halt pending ld", ld[1], 1);
        go(k + 30);
        @(negedge clk);
        check("halted busy", busy[1], 0);
        check("halted en", en[1], 0);
        check("halted stage_pc", spc[1], 8'h07);
        check("halted pc", pc[1], 8'h08);
        go(k + 31);
        run = 1'b1;
        bv  = 1'b1;
        bt  = 8'h20;
        go(k + 33);
        run = 1'b0;
        bv  = 1'b0;
        @(negedge clk);
        check("halted ignore pc", pc[1], 8'h08);
        check("halted ignore busy", busy[1], 0);
        check("halted ignore stage_pc", spc[1], 8'h07);
        go(k + 34);
        rst[1] = 1'b1;
        go(k + 35);
        @(negedge clk);
        check("halt rst pc", pc[1], 8'h00);
        check("halt rst busy", busy[1], 0);

        // RAM_LAT=2: branch during WAIT of fetch 3, then branch+halt
        go(k + 36);
        rst[1] = 1'b0;
        tick();
        run = 1'b1;
        k = cyc;
        expect_ld(1, 8'h00, k + 3);
        expect_ld(1, 8'h01, k + 6);
        expect_ld(1, 8'h02, k + 9);
        expect_ld(1, 8'h40, k + 14);
        go(k + 1);
        run = 1'b0;
        go(k + 11);
        bv = 1'b1;
        bt = 8'h40;
        go(k + 12);
        bv = 1'b0;
        @(negedge clk);
        check("br valid cleared", sv[1], 0);
        check("br ld", ld[1], 0);
        check("br issue en", en[1], 1);
        check("br issue addr", addr[1], 8'h40);
        go(k + 16);
        bv   = 1'b1;
        bt   = 8'h80;
        halt = 1'b1;
        go(k + 17);
        bv   = 1'b0;
        halt = 1'b0;
        @(negedge clk);
        check("br+halt busy", busy[1], 0);
        check("br+halt pc", pc[1], 8'h80);
        check("br+halt valid", sv[1], 0);
        go(k + 18);
        rst[1] = 1'b1;

        // RAM_LAT=1: wrap FF->00, reset during LOAD
        tick();
        rst[0] = 1'b0;
        tick();
        run = 1'b1;
        k = cyc;
        expect_ld(0, 8'hFF, k + 3);
        go(k + 1);
        run = 1'b0;
        bv  = 1'b1;
        bt  = 8'hFF;
        go(k + 2);
        bv = 1'b0;
        @(negedge clk);
        check("wrap issue en", en[0], 1);
        check("wrap issue addr", addr[0], 8'hFF);
        go(k + 3);
        @(negedge clk);
        check("wrap pc", pc[0], 8'h00);
        go(k + 4);
        @(negedge clk);
        check("wrap 2nd addr", addr[0], 8'h00);
        check("wrap 2nd en", en[0], 1);
        go(k + 5);
        rst[0] = 1'b1;
        @(negedge clk);
        check("rst load ld", ld[0], 0);
        check("rst load busy", busy[0], 0);
        check("rst load en", en[0], 0);
        go(k + 6);
        @(negedge clk);
        check("rst load pc", pc[0], 8'h00);
        check("rst load valid", sv[0], 0);
        check("rst load stage_pc", spc[0], 8'h00);
        check("rst load stage_instr", sinstr[0], 16'h0);

        go(cyc + 3);
        for (int g = 0; g < 3; g++)
            check($sformatf("dut%0d loads missing", g), sbq[g].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
